// File: rtl/ghist_queue_ctrl_if.sv
// ---------------------------------------------------------------------------
// ghist_queue_ctrl_if
// Bundles the handshake and macro-port signals of the global-history queue
// controller.
//   enq_valid / enq_ready / enq_bits : producer side (frontend predictor)
//   deq_valid / deq_ready / deq_bits : consumer side (commit/repair logic)
//   mem_R0_* / mem_W0_*              : 1R1W macro read and write ports
// Modports:
//   slave  : the queue controller
//   master : the environment around it (predictor, consumer, macro)
// ---------------------------------------------------------------------------
interface ghist_queue_ctrl_if #(
    parameter int WIDTH  = 72,
    parameter int ADDR_W = 6
);
    logic              enq_valid;
    logic              enq_ready;
    logic [WIDTH-1:0]  enq_bits;
    logic              deq_valid;
    logic              deq_ready;
    logic [WIDTH-1:0]  deq_bits;
    logic [ADDR_W-1:0] mem_R0_addr;
    logic              mem_R0_en;
    logic [WIDTH-1:0]  mem_R0_data;
    logic [ADDR_W-1:0] mem_W0_addr;
    logic              mem_W0_en;
    logic [WIDTH-1:0]  mem_W0_data;

    modport slave (
        input  enq_valid, enq_bits, deq_ready, mem_R0_data,
        output enq_ready, deq_valid, deq_bits,
               mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data
    );

    modport master (
        output enq_valid, enq_bits, deq_ready, mem_R0_data,
        input  enq_ready, deq_valid, deq_bits,
               mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data
    );
endinterface

// File: rtl/ghist_queue_ctrl.sv
// ---------------------------------------------------------------------------
// ghist_queue_ctrl
// Queue controller owning a 40 x 72 1R1W macro (registered read address,
// read data valid the cycle after read enable). Global-history snapshots are
// written on the enqueue side and streamed out on a valid/ready port backed
// by a one-entry holding register, giving one entry per cycle throughput.
//
// Ports:
//   clock  : single clock (also clocks the macro externally)
//   reset  : asynchronous, active-high; clears all controller state
//   flush  : synchronous queue clear, highest priority over enq/deq
//   bus    : ghist_queue_ctrl_if.slave (enq/deq handshakes, macro R0/W0)
//   count  : current occupancy
//
// Optional build macro:
//   GHIST_Q_FAST_ISSUE_EN : lets an enqueue into an empty fetch pipe issue its
//   read in the same cycle as its write, relying on the macro returning
//   same-edge write data. Empty-queue latency drops from 2 cycles to 1.
// ---------------------------------------------------------------------------
module ghist_queue_ctrl #(
    parameter int DEPTH  = 40,
    parameter int WIDTH  = 72,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    ghist_queue_ctrl_if.slave bus,
    output logic [CNT_W-1:0]  count
);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  unfetched_q, unfetched_d;
    logic              rdInflight_q, rdInflight_d;
    logic              holdValid_q, holdValid_d;
    logic [WIDTH-1:0]  hold_q, hold_d;

    logic enqReady;
    logic enqFire;
    logic deqValid;
    logic deqFire;
    logic outFree;
    logic rdIssue;

    // Pointers walk 0..DEPTH-1 and wrap explicitly since DEPTH need not be a
    // power of two.
    function automatic logic [ADDR_W-1:0] nextPtr(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    // Handshake qualifiers. A slot is only freed on deq_fire, so occupancy
    // alone decides whether a write can land without clobbering a fetched or
    // held entry.
    always_comb begin
        deqValid = rdInflight_q | holdValid_q;
        enqReady = (occ_q != CNT_W'(DEPTH)) & ~flush;
        enqFire  = bus.enq_valid & enqReady;
        deqFire  = deqValid & bus.deq_ready;
        outFree  = ~deqValid | bus.deq_ready;
`ifdef GHIST_Q_FAST_ISSUE_EN
        // An entry being written this cycle can be read at the same address
        // when nothing older is waiting; rptr equals wptr in that case.
        rdIssue  = ~flush & outFree & ((unfetched_q != '0) | enqFire);
`else
        rdIssue  = ~flush & outFree & (unfetched_q != '0);
`endif
    end

    // Next-state logic. Flush wipes every pointer and counter; a deq_fire in
    // the flush cycle is deliberately ignored. The holding register catches
    // read data that arrives while the consumer is stalled; the read-issue
    // rule keeps it from ever overlapping an in-flight read.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        occ_d        = occ_q;
        unfetched_d  = unfetched_q;
        rdInflight_d = rdIssue;
        holdValid_d  = holdValid_q;
        hold_d       = hold_q;
        if (flush) begin
            wptr_d       = '0;
            rptr_d       = '0;
            occ_d        = '0;
            unfetched_d  = '0;
            rdInflight_d = 1'b0;
            holdValid_d  = 1'b0;
        end else begin
            if (enqFire) wptr_d = nextPtr(wptr_q);
            if (rdIssue) rptr_d = nextPtr(rptr_q);
            case ({enqFire, deqFire})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
            unfetched_d = unfetched_q + CNT_W'(enqFire) - CNT_W'(rdIssue);
            if (rdInflight_q && !bus.deq_ready) begin
                hold_d      = bus.mem_R0_data;
                holdValid_d = 1'b1;
            end else if (holdValid_q && bus.deq_ready) begin
                holdValid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any in-flight read immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            occ_q        <= '0;
            unfetched_q  <= '0;
            rdInflight_q <= 1'b0;
            holdValid_q  <= 1'b0;
            hold_q       <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            occ_q        <= occ_d;
            unfetched_q  <= unfetched_d;
            rdInflight_q <= rdInflight_d;
            holdValid_q  <= holdValid_d;
            hold_q       <= hold_d;
        end
    end

    // Output drive: the macro ports mirror the fire/issue decisions, and the
    // dequeue data comes from the holding register when it is occupied.
    always_comb begin
        bus.enq_ready   = enqReady;
        bus.deq_valid   = deqValid;
        bus.deq_bits    = holdValid_q ? hold_q : bus.mem_R0_data;
        bus.mem_W0_en   = enqFire;
        bus.mem_W0_addr = wptr_q;
        bus.mem_W0_data = bus.enq_bits;
        bus.mem_R0_en   = rdIssue;
        bus.mem_R0_addr = rptr_q;
        count           = occ_q;
    end

endmodule

// File: tb/tb_ghist_queue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ghist_queue_ctrl
// Self-checking bench for ghist_queue_ctrl: a directed vector table for the
// basic latency and hold behaviour, followed by hand-written fill, backpressure,
// wrap, flush and asynchronous-reset sequences. A behavioural 1R1W macro with
// a registered read address sits on the mem ports.
// ---------------------------------------------------------------------------
module tb_ghist_queue_ctrl;

    localparam int DEPTH  = 40;
    localparam int WIDTH  = 72;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic [CNT_W-1:0] count;

    ghist_queue_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    ghist_queue_ctrl #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .bus  (bus),
        .count(count)
    );

    always #5 clock = ~clock;

    // Behavioural macro: registered read address, write-first on a same-edge
    // collision so the fast-issue build sees the freshly written entry.
    logic [WIDTH-1:0] macroMem [DEPTH];
    always @(posedge clock) begin
        if (bus.mem_W0_en) macroMem[int'(bus.mem_W0_addr)] <= bus.mem_W0_data;
        if (bus.mem_R0_en)
            bus.mem_R0_data <= (bus.mem_W0_en && bus.mem_W0_addr == bus.mem_R0_addr)
                               ? bus.mem_W0_data : macroMem[int'(bus.mem_R0_addr)];
    end

    typedef struct {
        logic             enqValid;
        logic [WIDTH-1:0] enqBits;
        logic             deqReady;
        logic             flushIn;
        logic             expEnqReady;
        logic             expDeqValid;
        logic [WIDTH-1:0] expDeqBits;
        logic [CNT_W-1:0] expCount;
        logic             expWEn;
        logic [ADDR_W-1:0] expWAddr;
        logic             expREn;
        logic [ADDR_W-1:0] expRAddr;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] sb[$];
    int               checks = 0;
    int               errors = 0;
    int               modelW = 0;
    int               modelR = 0;
    int               lastW  = -1;
    int               lastR  = -1;
    bit               sawWrapW = 0;
    bit               sawWrapR = 0;

    function automatic vec_t mk(input logic ev, input logic [WIDTH-1:0] eb,
                                input logic dr, input logic fl,
                                input logic xRdy, input logic xDv,
                                input logic [WIDTH-1:0] xBits, input int xCnt,
                                input logic xW, input int xWa,
                                input logic xR, input int xRa);
        vec_t v;
        v.enqValid = ev;   v.enqBits = eb;    v.deqReady = dr;  v.flushIn = fl;
        v.expEnqReady = xRdy; v.expDeqValid = xDv; v.expDeqBits = xBits;
        v.expCount = CNT_W'(xCnt);
        v.expWEn = xW; v.expWAddr = ADDR_W'(xWa);
        v.expREn = xR; v.expRAddr = ADDR_W'(xRa);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after the falling edge and return one time unit
    // before the next rising edge, where outputs are sampled.
    task automatic applyStimulus(input logic ev, input logic [WIDTH-1:0] eb,
                                 input logic dr, input logic fl);
        @(negedge clock);
        bus.enq_valid = ev;
        bus.enq_bits  = eb;
        bus.deq_ready = dr;
        flush         = fl;
        #4;
    endtask

    // Macro addresses must follow the bench's own wrapping pointer model.
    task automatic trackAddrs(input string tag);
        if (bus.mem_W0_en) begin
            checkOutput({tag, "_wAddr"}, bus.mem_W0_addr, modelW);
            if (lastW == DEPTH - 1 && bus.mem_W0_addr == 0) sawWrapW = 1;
            lastW  = int'(bus.mem_W0_addr);
            modelW = (modelW + 1) % DEPTH;
        end
        if (bus.mem_R0_en) begin
            checkOutput({tag, "_rAddr"}, bus.mem_R0_addr, modelR);
            if (lastR == DEPTH - 1 && bus.mem_R0_addr == 0) sawWrapR = 1;
            lastR  = int'(bus.mem_R0_addr);
            modelR = (modelR + 1) % DEPTH;
        end
    endtask

    task automatic popAndCheck(input string name, input logic [WIDTH-1:0] act);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got %0h, expected no dequeue (queue model empty)", name, act);
        end else begin
            checkOutput(name, act, sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.enq_valid = 1'b0;
        bus.enq_bits  = '0;
        bus.deq_ready = 1'b0;
        flush         = 1'b0;
        reset         = 1'b1;
        #1;
        checkOutput("rst_enqReady", bus.enq_ready, 1);
        checkOutput("rst_deqValid", bus.deq_valid, 0);
        checkOutput("rst_count",    count,         0);
        checkOutput("rst_rEn",      bus.mem_R0_en, 0);
        checkOutput("rst_wEn",      bus.mem_W0_en, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // ---------------- vector table ----------------
        vecs.push_back(mk(0, 0,      1, 0, 1, 0, 0,      0, 0, 0, 0, 0));
`ifdef GHIST_Q_FAST_ISSUE_EN
        vecs.push_back(mk(1, 'hA5,   1, 0, 1, 0, 0,      0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,      1, 0, 1, 1, 'hA5,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,      1, 0, 1, 0, 0,      0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,      1, 0, 1, 0, 0,      0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 'h11,   0, 0, 1, 0, 0,      0, 1, 1, 1, 1));
        vecs.push_back(mk(1, 'h22,   0, 0, 1, 1, 'h11,   1, 1, 2, 0, 0));
`else
        vecs.push_back(mk(1, 'hA5,   1, 0, 1, 0, 0,      0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,      1, 0, 1, 0, 0,      1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,      1, 0, 1, 1, 'hA5,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,      1, 0, 1, 0, 0,      0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 'h11,   0, 0, 1, 0, 0,      0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 'h22,   0, 0, 1, 0, 0,      1, 1, 2, 1, 1));
`endif
        vecs.push_back(mk(0, 0,      0, 0, 1, 1, 'h11,   2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,      0, 0, 1, 1, 'h11,   2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,      1, 0, 1, 1, 'h11,   2, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0,      1, 0, 1, 1, 'h22,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,      1, 0, 1, 0, 0,      0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].enqValid, vecs[i].enqBits, vecs[i].deqReady, vecs[i].flushIn);
            checkOutput($sformatf("row%0d_enqReady", i), bus.enq_ready, vecs[i].expEnqReady);
            checkOutput($sformatf("row%0d_deqValid", i), bus.deq_valid, vecs[i].expDeqValid);
            checkOutput($sformatf("row%0d_count", i),    count,         vecs[i].expCount);
            checkOutput($sformatf("row%0d_wEn", i),      bus.mem_W0_en, vecs[i].expWEn);
            checkOutput($sformatf("row%0d_rEn", i),      bus.mem_R0_en, vecs[i].expREn);
            if (vecs[i].expDeqValid)
                checkOutput($sformatf("row%0d_deqBits", i), bus.deq_bits, vecs[i].expDeqBits);
            if (vecs[i].expWEn)
                checkOutput($sformatf("row%0d_wAddr", i), bus.mem_W0_addr, vecs[i].expWAddr);
            if (vecs[i].expREn)
                checkOutput($sformatf("row%0d_rAddr", i), bus.mem_R0_addr, vecs[i].expRAddr);
        end
        modelW = 3;
        modelR = 3;

        // ---------------- fill to DEPTH, then drain ----------------
        $display("[TB] fill and drain");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, WIDTH'(i), 0, 0);
            checkOutput("fill_enqReady", bus.enq_ready, 1);
            trackAddrs("fill");
        end
        applyStimulus(1, WIDTH'(99), 0, 0);
        checkOutput("full_enqReady", bus.enq_ready, 0);
        checkOutput("full_wEn",      bus.mem_W0_en, 0);
        checkOutput("full_count",    count,         DEPTH);
        begin
            int got = 0;
            int gaps = 0;
            for (int c = 0; c < 200 && got < DEPTH; c++) begin
                applyStimulus(0, 0, 1, 0);
                trackAddrs("drain");
                if (bus.deq_valid) begin
                    checkOutput("drain_data", bus.deq_bits, WIDTH'(got));
                    got++;
                end else if (got > 0) begin
                    gaps++;
                end
            end
            checkOutput("drain_total", WIDTH'(got), DEPTH);
            checkOutput("drain_gaps",  WIDTH'(gaps), 0);
        end
        applyStimulus(0, 0, 1, 0);
        checkOutput("drain_count", count, 0);

        // ---------------- backpressure stream ----------------
        $display("[TB] backpressure stream");
        begin
            int sent = 0;
            int rcvd = 0;
            for (int c = 0; c < 1000 && rcvd < 100; c++) begin
                applyStimulus(sent < 100, WIDTH'(32'h1000 + sent), (c % 2) == 0, 0);
                trackAddrs("bp");
                if (bus.enq_valid && bus.enq_ready) begin
                    sb.push_back(bus.enq_bits);
                    sent++;
                end
                if (bus.deq_valid && bus.deq_ready) begin
                    popAndCheck("bp_data", bus.deq_bits);
                    rcvd++;
                end
            end
            checkOutput("bp_received", WIDTH'(rcvd), 100);
            checkOutput("bp_leftover", WIDTH'(sb.size()), 0);
        end
        applyStimulus(0, 0, 1, 0);
        checkOutput("bp_count", count, 0);

        // ---------------- wrap at full rate ----------------
        $display("[TB] wrap at full rate");
        sawWrapW = 0;
        sawWrapR = 0;
        begin
            int deqs = 0;
            for (int c = 0; c < 60; c++) begin
                applyStimulus(1, WIDTH'(32'h2000 + c), 1, 0);
                checkOutput("wrap_enqReady", bus.enq_ready, 1);
                trackAddrs("wrap");
                if (bus.enq_valid && bus.enq_ready) sb.push_back(bus.enq_bits);
                if (bus.deq_valid && bus.deq_ready) begin
                    popAndCheck("wrap_data", bus.deq_bits);
                    deqs++;
                end
            end
`ifdef GHIST_Q_FAST_ISSUE_EN
            checkOutput("wrap_throughput", WIDTH'(deqs), 59);
`else
            checkOutput("wrap_throughput", WIDTH'(deqs), 58);
`endif
            for (int c = 0; c < 10 && sb.size() > 0; c++) begin
                applyStimulus(0, 0, 1, 0);
                trackAddrs("wrapDrain");
                if (bus.deq_valid) popAndCheck("wrap_drainData", bus.deq_bits);
            end
            checkOutput("wrap_leftover", WIDTH'(sb.size()), 0);
            checkOutput("wrap_wSeen39to0", WIDTH'(sawWrapW), 1);
            checkOutput("wrap_rSeen39to0", WIDTH'(sawWrapR), 1);
        end

        // ---------------- flush with a read in flight ----------------
        $display("[TB] flush");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, WIDTH'(32'h70 + i), 0, 0);
            trackAddrs("flFill");
        end
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, WIDTH'(32'h77), 1, 0);
        trackAddrs("flPre");
        checkOutput("flPre_count",    count,         7);
        checkOutput("flPre_deqValid", bus.deq_valid, 1);
        checkOutput("flPre_rEn",      bus.mem_R0_en, 1);
        applyStimulus(1, WIDTH'(32'h88), 1, 1);
        checkOutput("flush_enqReady", bus.enq_ready, 0);
        checkOutput("flush_wEn",      bus.mem_W0_en, 0);
        checkOutput("flush_rEn",      bus.mem_R0_en, 0);
        checkOutput("flush_deqValid", bus.deq_valid, 1);
        checkOutput("flush_count",    count,         7);
        applyStimulus(0, 0, 1, 0);
        checkOutput("postFlush_count",    count,         0);
        checkOutput("postFlush_deqValid", bus.deq_valid, 0);
        checkOutput("postFlush_enqReady", bus.enq_ready, 1);
        modelW = 0;
        modelR = 0;
        applyStimulus(1, WIDTH'(32'hF1), 1, 0);
        checkOutput("postFlush_wEn", bus.mem_W0_en, 1);
        trackAddrs("postFlush");
        begin
            int got = 0;
            for (int c = 0; c < 5 && got == 0; c++) begin
                applyStimulus(0, 0, 1, 0);
                trackAddrs("postFlushRd");
                if (bus.deq_valid) begin
                    checkOutput("postFlush_data", bus.deq_bits, WIDTH'(32'hF1));
                    got++;
                end
            end
            checkOutput("postFlush_got", WIDTH'(got), 1);
        end

        // ---------------- asynchronous reset mid-stream ----------------
        $display("[TB] async reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, WIDTH'(32'hB0 + i), 0, 0);
            trackAddrs("arFill");
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("arPre_deqValid", bus.deq_valid, 1);
        checkOutput("arPre_count",    count,         3);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_deqValid", bus.deq_valid, 0);
        checkOutput("ar_count",    count,         0);
        checkOutput("ar_enqReady", bus.enq_ready, 1);
        checkOutput("ar_rEn",      bus.mem_R0_en, 0);
        checkOutput("ar_wEn",      bus.mem_W0_en, 0);
        @(negedge clock);
        reset  = 1'b0;
        modelW = 0;
        modelR = 0;
        applyStimulus(1, WIDTH'(32'hBEEF), 1, 0);
        checkOutput("arPost_wEn", bus.mem_W0_en, 1);
        trackAddrs("arPost");
        begin
            int got = 0;
            for (int c = 0; c < 5 && got == 0; c++) begin
                applyStimulus(0, 0, 1, 0);
                trackAddrs("arPostRd");
                if (bus.deq_valid) begin
                    checkOutput("arPost_data", bus.deq_bits, WIDTH'(32'hBEEF));
                    got++;
                end
            end
            checkOutput("arPost_got", WIDTH'(got), 1);
        end
        applyStimulus(0, 0, 1, 0);
        checkOutput("arPost_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
